schedule: RTL
=============

// Module: schedule
// PURPOSE
//  Consumer end of the CHECK_* interface: the scheduler stage after check. It
//  tracks outstanding register writes in a 32-entry busy scoreboard and
//  issues one instruction per cycle to execute when its operands are free.
//  On a RAW or WAW hazard it raises STALL to hold the check stage.
// PARAMETERS
//  REG_NUM     32  architectural registers tracked (x0 never tracked)
//  REG_AW       5  register index width, log2(REG_NUM)
// PORTS
//  CLK               in   1   sole clock, rising edge
//  RST_N             in   1   reset, asynchronous, active-low
//  FLUSH             in   1   kill held and issuing instruction, clear scoreboard
//  MEM_WAIT          in   1   global freeze from memory
//  CHECK_PC          in  32   instruction PC
//  CHECK_OPCODE      in   7   opcode; 7'b0 = bubble
//  CHECK_RD/RS1/RS2  in   5   register indices
//  CHECK_CSR         in  12   CSR address
//  CHECK_FUNCT3      in   3   funct3
//  CHECK_FUNCT7      in   7   funct7
//  CHECK_IMM         in  32   immediate
//  WB_VALID          in   1   writeback retiring a register this cycle
//  WB_RD             in   5   register being retired
//  STALL             out  1   combinational; hold check stage this cycle
//  SCHEDULE_VALID    out  1   registered; SCHEDULE_* carries a real instruction
//  SCHEDULE_PC..IMM  out  --  registered copies of CHECK_* (same widths/names)
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - Reset (RST_N=0): all SCHEDULE_* = 0, SCHEDULE_VALID = 0, busy = 0.
//    STALL is combinational and drives 0 because busy = 0.
//  - Operand use, decoded from opcode:
//    0110011/0100011/1100011 use rs1+rs2;
//    0010011/0000011/1100111 use rs1;
//    1110011 uses rs1 if funct3[2]==0;
//    0110111/0010111/1101111 use none.
//  - rd write: every opcode except 0100011, 1100011 and bubble, and only
//    when rd != 0.
//  - hazard = valid instruction AND (used rs busy OR writing rd busy).
//  - STALL = hazard AND !MEM_WAIT AND !FLUSH.
//  - Per-cycle priority is FLUSH > MEM_WAIT > hazard > issue:
//    FLUSH: outputs <= 0, VALID <= 0, busy <= 0. WB in that cycle is ignored.
//    MEM_WAIT: outputs hold. busy still clears on WB_VALID.
//    hazard: outputs <= 0 bubble, VALID <= 0. busy clears on WB.
//    issue: outputs <= CHECK_*, VALID <= (opcode != 0), busy[rd] set if rd write.
//  - Latency: 1 cycle, CHECK_* to SCHEDULE_*.
//  - Simultaneous WB_RD == issuing rd: the set wins, so busy[rd] stays 1.
//  - WB_RD == 0 is ignored.
//  - busy[0] is hard-wired to 0.
//  - Bubble input (opcode 0): never stalls, issues VALID = 0.
// CONFIGURATION
//  SCHEDULE_WB_BYPASS_EN defined:
//    the hazard check uses busy & ~(WB_VALID << WB_RD). An instruction waiting
//    on the register retiring this cycle issues in this same cycle.
//  Undefined:
//    the hazard check uses the registered busy vector. The waiting
//    instruction issues one cycle after the WB cycle.
// STRUCTURE
//  Shared package pipeline_pkg:
//    opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
//    OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC, OP_SYSTEM, OP_BUBBLE = 7'b0);
//    REG_AW.
//  Sub-module schedule_scoreboard:
//    busy vector with set/clear/flush ports;
//    combinational busy query for rs1, rs2 and rd.
// TESTING
//  1. Reset mid-run:
//     drop RST_N with busy = 32'h0000_00F0.
//     Requires VALID = 0, busy = 0 and STALL = 0 immediately, without waiting
//     for CLK.
//  2. RAW:
//     issue add x5,x1,x2, then add x6,x5,x3; no WB.
//     Requires STALL = 1 and bubbles until WB_VALID with WB_RD = 5.
//     Bypass build: issue in the WB cycle. Non-bypass build: issue 1 cycle later.
//  3. WAW plus same-cycle set/clear:
//     issue lui x7 while WB_RD = 7 in the same cycle.
//     Requires busy[7] = 1 afterwards, and a following lui x7 to stall.
//  4. x0 and bubble:
//     issue addi x0,x0,1 twice, then opcode 0.
//     Requires no stall, busy = 0, and the last output VALID = 0.
//  5. MEM_WAIT:
//     pending x5 with a dependent instruction waiting; assert MEM_WAIT for
//     3 cycles with WB_RD = 5 in cycle 2.
//     Requires outputs held, STALL = 0, busy[5] cleared, and the dependent
//     instruction issuing on the first cycle after MEM_WAIT drops.
//  6. FLUSH during hazard:
//     requires busy = 0, outputs 0, STALL = 0 in the flush cycle; a WB in
//     that cycle is ignored.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcode constants, register index width, the instruction
// bundle passed between stages, and operand-use decode helpers.
package pipeline_pkg;

  localparam int unsigned REG_NUM = 32;
  localparam int unsigned REG_AW  = 5;

  localparam logic [6:0] OP_BUBBLE = 7'b0000000;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0]       pc;
    logic [6:0]        opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [11:0]       csr;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
  } instr_t;

  function automatic logic uses_rs1(input logic [6:0] op, input logic [2:0] funct3);
    case (op)
      OP_OP, OP_STORE, OP_BRANCH, OP_OPIMM, OP_LOAD, OP_JALR: uses_rs1 = 1'b1;
      OP_SYSTEM:                                                uses_rs1 = ~funct3[2];
      default:                                                  uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    case (op)
      OP_OP, OP_STORE, OP_BRANCH: uses_rs2 = 1'b1;
      default:                    uses_rs2 = 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [6:0] op, input logic [REG_AW-1:0] rd);
    case (op)
      OP_BUBBLE, OP_STORE, OP_BRANCH: writes_rd = 1'b0;
      default:                        writes_rd = (rd != '0);
    endcase
  endfunction

endpackage

// File: rtl/schedule_scoreboard.sv
// Busy scoreboard for outstanding register writes with set/clear/flush and operand query.
// SCHEDULE_WB_BYPASS_EN: queries ignore the register being retired this cycle.
module schedule_scoreboard
  import pipeline_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              flush,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_rd,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rd_busy
);

  logic [REG_NUM-1:0] busy_q, busy_d, set_mask, clr_mask, query;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_rd] = 1'b1;
    if (clr_en) clr_mask[clr_rd] = 1'b1;
    // Set is applied after clear so a same-cycle retire of the issuing rd keeps it busy.
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
    if (flush) busy_d = '0;
  end

`ifdef SCHEDULE_WB_BYPASS_EN
  assign query = busy_q & ~clr_mask;
`else
  assign query = busy_q;
`endif

  assign rs1_busy = query[rs1];
  assign rs2_busy = query[rs2];
  assign rd_busy  = query[rd];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/schedule.sv
// Scheduler stage: issues one checked instruction per cycle once its operands are free.
// Build option SCHEDULE_WB_BYPASS_EN lets a waiter issue in its register's writeback cycle.
module schedule
  import pipeline_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              FLUSH,
  input  logic              MEM_WAIT,
  input  logic [31:0]       CHECK_PC,
  input  logic [6:0]        CHECK_OPCODE,
  input  logic [REG_AW-1:0] CHECK_RD,
  input  logic [REG_AW-1:0] CHECK_RS1,
  input  logic [REG_AW-1:0] CHECK_RS2,
  input  logic [11:0]       CHECK_CSR,
  input  logic [2:0]        CHECK_FUNCT3,
  input  logic [6:0]        CHECK_FUNCT7,
  input  logic [31:0]       CHECK_IMM,
  input  logic              WB_VALID,
  input  logic [REG_AW-1:0] WB_RD,
  output logic              STALL,
  output logic              SCHEDULE_VALID,
  output logic [31:0]       SCHEDULE_PC,
  output logic [6:0]        SCHEDULE_OPCODE,
  output logic [REG_AW-1:0] SCHEDULE_RD,
  output logic [REG_AW-1:0] SCHEDULE_RS1,
  output logic [REG_AW-1:0] SCHEDULE_RS2,
  output logic [11:0]       SCHEDULE_CSR,
  output logic [2:0]        SCHEDULE_FUNCT3,
  output logic [6:0]        SCHEDULE_FUNCT7,
  output logic [31:0]       SCHEDULE_IMM
);

  instr_t check_instr, sched_q;
  logic   valid_q;
  logic   in_valid, use1, use2, wr_rd, hazard, issue;
  logic   rs1_busy, rs2_busy, rd_busy;

  always_comb begin
    check_instr.pc     = CHECK_PC;
    check_instr.opcode = CHECK_OPCODE;
    check_instr.rd     = CHECK_RD;
    check_instr.rs1    = CHECK_RS1;
    check_instr.rs2    = CHECK_RS2;
    check_instr.csr    = CHECK_CSR;
    check_instr.funct3 = CHECK_FUNCT3;
    check_instr.funct7 = CHECK_FUNCT7;
    check_instr.imm    = CHECK_IMM;
  end

  assign in_valid = (CHECK_OPCODE != OP_BUBBLE);
  assign use1     = uses_rs1(CHECK_OPCODE, CHECK_FUNCT3);
  assign use2     = uses_rs2(CHECK_OPCODE);
  assign wr_rd    = writes_rd(CHECK_OPCODE, CHECK_RD);
  assign hazard   = in_valid & ((use1 & rs1_busy) | (use2 & rs2_busy) | (wr_rd & rd_busy));
  assign STALL    = hazard & ~MEM_WAIT & ~FLUSH;
  assign issue    = ~FLUSH & ~MEM_WAIT & ~hazard;

  schedule_scoreboard u_scoreboard (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .flush    (FLUSH),
    .set_en   (issue & wr_rd),
    .set_rd   (CHECK_RD),
    .clr_en   (WB_VALID & (WB_RD != '0)),
    .clr_rd   (WB_RD),
    .rs1      (CHECK_RS1),
    .rs2      (CHECK_RS2),
    .rd       (CHECK_RD),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy)
  );

  // MEM_WAIT holds the issued instruction; FLUSH and hazards insert a zero bubble.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sched_q <= '0;
      valid_q <= 1'b0;
    end else if (FLUSH) begin
      sched_q <= '0;
      valid_q <= 1'b0;
    end else if (!MEM_WAIT) begin
      if (hazard) begin
        sched_q <= '0;
        valid_q <= 1'b0;
      end else begin
        sched_q <= check_instr;
        valid_q <= in_valid;
      end
    end
  end

  assign SCHEDULE_VALID  = valid_q;
  assign SCHEDULE_PC     = sched_q.pc;
  assign SCHEDULE_OPCODE = sched_q.opcode;
  assign SCHEDULE_RD     = sched_q.rd;
  assign SCHEDULE_RS1    = sched_q.rs1;
  assign SCHEDULE_RS2    = sched_q.rs2;
  assign SCHEDULE_CSR    = sched_q.csr;
  assign SCHEDULE_FUNCT3 = sched_q.funct3;
  assign SCHEDULE_FUNCT7 = sched_q.funct7;
  assign SCHEDULE_IMM    = sched_q.imm;

endmodule
